route_dispatch: RTL and testbench

ROUTE_DISPATCH -- requirements
Module: route_dispatch

---
 rtl/route_dispatch_pkg.sv | 24 ++
 rtl/route_fifo.sv | 82 ++++++++
 rtl/route_dispatch.sv | 130 +++++++++++++
 tb/tb_route_dispatch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/route_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : route_dispatch_pkg
//  Description : Shared types for the in-order route dispatcher: FSM state
//                encoding, destination index type and destination count.
//  Revision    : 1.0 - initial release
// ============================================================================
package route_dispatch_pkg;

   localparam int NUM_DEST = 4;
   localparam int DEST_W   = 2;

   typedef logic [DEST_W-1:0] dest_t;

   // IDLE: FIFO empty, ISSUE: head is popped on the next edge,
   // BLOCK: head destination busy, everything behind it waits.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BLOCK = 2'd2
   } state_e;

endpackage : route_dispatch_pkg
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : route_fifo
//  Description : Synchronous-write FIFO of {dest, data} entries with
//                registered pointers, full/empty/level, and a peek at the
//                entry behind the head so the dispatcher can look ahead.
//  Revision    : 1.0 - initial release
// ============================================================================
module route_fifo import route_dispatch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int DW    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  dest_t                  wr_dest_i,
   input  logic [DW-1:0]          wr_data_i,
   output dest_t                  head_dest_o,
   output logic [DW-1:0]          head_data_o,
   output dest_t                  follow_dest_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   dest_t         dest_mem_q [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] rd_nxt_w;
   logic [LW-1:0] level_q, level_d;
   logic          push_w, pop_w;

   assign full_o        = (level_q == LW'(DEPTH));
   assign empty_o       = (level_q == '0);
   assign level_o       = level_q;
   assign push_w        = push_i && !full_o;
   assign pop_w         = pop_i && !empty_o;
   assign rd_nxt_w      = rd_ptr_q + AW'(1);
   assign head_dest_o   = dest_mem_q[rd_ptr_q];
   assign head_data_o   = data_mem_q[rd_ptr_q];
   assign follow_dest_o = dest_mem_q[rd_nxt_w];

   // Storage write; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (push_w) begin
         dest_mem_q[wr_ptr_q] <= wr_dest_i;
         data_mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_d = rd_nxt_w;
      if (push_w && !pop_w)      level_d = level_q + LW'(1);
      else if (!push_w && pop_w) level_d = level_q - LW'(1);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule : route_fifo
`default_nettype wire

// File: rtl/route_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : route_dispatch
//  Description : Buffers {dest, data} entries and dispatches them strictly in
//                order to a 1-to-4 demux through registered data/select and a
//                one-cycle strobe. A busy head destination stalls the queue.
//                Optional macro ROUTE_DISPATCH_COUNT_EN adds per-destination
//                8-bit wrapping dispatch counters on port dispatch_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module route_dispatch import route_dispatch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int DW    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DW-1:0]          wr_data,
   input  dest_t                  wr_dest,
   input  logic [NUM_DEST-1:0]    dest_busy,
   output logic [DW-1:0]          data_out,
   output dest_t                  sel_out,
   output logic                   out_strobe,
   output logic [$clog2(DEPTH):0] level
`ifdef ROUTE_DISPATCH_COUNT_EN
   ,
   output logic [8*NUM_DEST-1:0]  dispatch_cnt
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;

   state_e        state_q, state_d;
   logic          ready_q;
   logic [DW-1:0] data_out_q;
   dest_t         sel_out_q;
   logic          strobe_q;

   logic          push_w, pop_w;
   logic          full_w, empty_w;
   dest_t         head_dest_w, follow_dest_w, next_head_w;
   logic [DW-1:0] head_data_w;
   logic [LW-1:0] level_w;

   route_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_i        (push_w),
      .pop_i         (pop_w),
      .wr_dest_i     (wr_dest),
      .wr_data_i     (wr_data),
      .head_dest_o   (head_dest_w),
      .head_data_o   (head_data_w),
      .follow_dest_o (follow_dest_w),
      .full_o        (full_w),
      .empty_o       (empty_w),
      .level_o       (level_w)
   );

   // Full blocks pushes even when the head leaves this same cycle.
   assign wr_ready   = ready_q && !full_w;
   assign push_w     = wr_valid && wr_ready;
   assign pop_w      = (state_q == ISSUE) && !empty_w;
   // Head after a pop: the entry behind it, or the one arriving now if none.
   assign next_head_w = (level_w > LW'(1)) ? follow_dest_w : wr_dest;

   assign level      = level_w;
   assign data_out   = data_out_q;
   assign sel_out    = sel_out_q;
   assign out_strobe = strobe_q;

   // Next state looks at the FIFO as it will be after this edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (push_w) state_d = dest_busy[wr_dest] ? BLOCK : ISSUE;
         end
         ISSUE: begin
            if (level_w == LW'(1) && !push_w) state_d = IDLE;
            else state_d = dest_busy[next_head_w] ? BLOCK : ISSUE;
         end
         BLOCK: begin
            if (!dest_busy[head_dest_w]) state_d = ISSUE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, ready enable and demux-facing output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         data_out_q <= '0;
         sel_out_q  <= '0;
         strobe_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= 1'b1;
         strobe_q <= pop_w;
         if (pop_w) begin
            data_out_q <= head_data_w;
            sel_out_q  <= head_dest_w;
         end
      end
   end

`ifdef ROUTE_DISPATCH_COUNT_EN
   generate
      for (genvar d = 0; d < NUM_DEST; d++) begin : g_cnt
         logic [7:0] cnt_q;

         // Count dispatches to destination d, wrapping at 255.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else if (pop_w && head_dest_w == dest_t'(d)) cnt_q <= cnt_q + 8'd1;
         end

         assign dispatch_cnt[8*d +: 8] = cnt_q;
      end
   endgenerate
`endif

endmodule : route_dispatch
`default_nettype wire

// File: tb/tb_route_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_route_dispatch
//  Description : Directed self-checking bench for route_dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_route_dispatch;

   localparam int DEPTH = 4;
   localparam int DW    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          wr_valid  = 1'b0;
   logic [DW-1:0] wr_data   = '0;
   logic [1:0]    wr_dest   = '0;
   logic [3:0]    dest_busy = '0;
   logic          wr_ready;
   logic [DW-1:0] data_out;
   logic [1:0]    sel_out;
   logic          out_strobe;
   logic [LW-1:0] level;
`ifdef ROUTE_DISPATCH_COUNT_EN
   logic [31:0]   dispatch_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   route_dispatch #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_dest      (wr_dest),
      .dest_busy    (dest_busy),
      .data_out     (data_out),
      .sel_out      (sel_out),
      .out_strobe   (out_strobe),
      .level        (level)
`ifdef ROUTE_DISPATCH_COUNT_EN
      ,
      .dispatch_cnt (dispatch_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check strobe/select/data/level together.
   task automatic exp_o(input string tag, input logic s, input logic [1:0] sel,
                        input logic [DW-1:0] d, input logic [LW-1:0] lv);
      chk({tag, ".strobe"}, 32'(out_strobe), 32'(s));
      chk({tag, ".sel"},    32'(sel_out),    32'(sel));
      chk({tag, ".data"},   32'(data_out),   32'(d));
      chk({tag, ".level"},  32'(level),      32'(lv));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] dst, input logic [DW-1:0] dat);
      wr_valid = 1'b1;
      wr_dest  = dst;
      wr_data  = dat;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      // Reset state, then ready rises only on the first edge after release.
      #1;
      exp_o("rst", 1'b0, 2'd0, 4'h0, 3'd0);
      chk("rst.ready", 32'(wr_ready), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rel.ready_pre", 32'(wr_ready), 32'd0);
      tick();
      chk("rel.ready_post", 32'(wr_ready), 32'd1);

      // Single entry: strobe one edge after the push, then outputs hold.
      push(2'd2, 4'hA);
      exp_o("t1.push", 1'b0, 2'd0, 4'h0, 3'd1);
      tick();
      exp_o("t1.pop", 1'b1, 2'd2, 4'hA, 3'd0);
      tick();
      exp_o("t1.hold", 1'b0, 2'd2, 4'hA, 3'd0);

      // Fill to 4 while all busy, release, drain in order back-to-back.
      dest_busy = 4'hF;
      push(2'd0, 4'h1);
      push(2'd1, 4'h2);
      push(2'd2, 4'h3);
      push(2'd3, 4'h4);
      chk("t2.full_level", 32'(level), 32'd4);
      chk("t2.full_ready", 32'(wr_ready), 32'd0);
      dest_busy = 4'h0;
      tick();   // BLOCK sees destination free -> ISSUE
      exp_o("t2.unblock", 1'b0, 2'd2, 4'hA, 3'd4);
      tick();
      exp_o("t2.p0", 1'b1, 2'd0, 4'h1, 3'd3);
      chk("t2.ready_back", 32'(wr_ready), 32'd1);
      tick();
      exp_o("t2.p1", 1'b1, 2'd1, 4'h2, 3'd2);
      tick();
      exp_o("t2.p2", 1'b1, 2'd2, 4'h3, 3'd1);
      tick();
      exp_o("t2.p3", 1'b1, 2'd3, 4'h4, 3'd0);
      tick();
      exp_o("t2.idle", 1'b0, 2'd3, 4'h4, 3'd0);

      // Blocked head (dest 1) stalls a younger free entry (dest 0).
      dest_busy = 4'b0010;
      push(2'd1, 4'h5);
      push(2'd0, 4'h6);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_o("t3.blocked", 1'b0, 2'd3, 4'h4, 3'd2);
      end
      dest_busy = 4'h0;
      tick();
      exp_o("t3.unblock", 1'b0, 2'd3, 4'h4, 3'd2);
      tick();
      exp_o("t3.p1", 1'b1, 2'd1, 4'h5, 3'd1);
      tick();
      exp_o("t3.p0", 1'b1, 2'd0, 4'h6, 3'd0);
      tick();
      chk("t3.quiet", 32'(out_strobe), 32'd0);

      // Full FIFO with wr_valid held across the first pop; three fills wrap pointers.
      for (int f = 0; f < 3; f++) begin
         dest_busy = 4'hF;
         for (int i = 0; i < 4; i++) push(2'(i), 4'(4*f + i + 1));
         chk("t4.full", 32'(level), 32'd4);
         wr_valid  = 1'b1;
         wr_dest   = 2'd2;
         wr_data   = 4'(15 - f);
         dest_busy = 4'h0;
         tick();
         exp_o("t4.unblock", 1'b0, sel_out, data_out, 3'd4);
         chk("t4.ready_full", 32'(wr_ready), 32'd0);
         tick();   // pop; push refused because level was 4 this cycle
         exp_o("t4.pop0", 1'b1, 2'd0, 4'(4*f + 1), 3'd3);
         chk("t4.ready_after", 32'(wr_ready), 32'd1);
         tick();   // push and pop together
         exp_o("t4.pop1", 1'b1, 2'd1, 4'(4*f + 2), 3'd3);
         wr_valid = 1'b0;
         tick();
         exp_o("t4.pop2", 1'b1, 2'd2, 4'(4*f + 3), 3'd2);
         tick();
         exp_o("t4.pop3", 1'b1, 2'd3, 4'(4*f + 4), 3'd1);
         tick();
         exp_o("t4.popx", 1'b1, 2'd2, 4'(15 - f), 3'd0);
         tick();
         chk("t4.quiet", 32'(out_strobe), 32'd0);
      end

      // Asynchronous reset with 3 entries queued discards them.
      dest_busy = 4'hF;
      push(2'd0, 4'h7);
      push(2'd1, 4'h8);
      push(2'd2, 4'h9);
      chk("t5.level3", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      exp_o("t5.async", 1'b0, 2'd0, 4'h0, 3'd0);
      chk("t5.ready", 32'(wr_ready), 32'd0);
      tick();
      rst_n     = 1'b1;
      dest_busy = 4'h0;
      chk("t5.ready_pre", 32'(wr_ready), 32'd0);
      tick();
      chk("t5.ready_post", 32'(wr_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         exp_o("t5.empty", 1'b0, 2'd0, 4'h0, 3'd0);
         tick();
      end
      push(2'd3, 4'h6);
      exp_o("t5.push", 1'b0, 2'd0, 4'h0, 3'd1);
      tick();
      exp_o("t5.pop", 1'b1, 2'd3, 4'h6, 3'd0);

`ifdef ROUTE_DISPATCH_COUNT_EN
      // 257 dispatches to destination 3 wrap its counter to 1.
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.cnt_rst", dispatch_cnt, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      wr_valid = 1'b1;
      wr_dest  = 2'd3;
      wr_data  = 4'h5;
      for (int i = 0; i < 257; i++) tick();
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t6.level", 32'(level), 32'd0);
      chk("t6.cnt", dispatch_cnt, 32'h0100_0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_route_dispatch
`default_nettype wire
